coin_bank: RTL and testbench
============================

Name: coin_bank

Overview:
- Credit and coin-handling back end for the coffee vending controller.
- Accepts coin insertions and accumulates credit.
- Exposes the running credit and a coin-insert pulse to the controller.
- Deducts the coffee price and times the brew when the controller requests coffee.
- Pays change out coin by coin, through a req/ack dispenser handshake, when the controller requests a return.

Parameters:
- COFFEE_VAL, 300, price deducted per brew (credit units).
- BREW_CYCLES, 1000, clk cycles from price deduction to the coffee_out pulse; must be >= 2.
- CREDIT_MAX, 9990, largest credit held; coins that would exceed it are rejected.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- coin_ins  in  1  one-cycle pulse from the coin mech: a coin is present.
- coin_type  in  2  denomination of coin_ins: 0=10, 1=50, 2=100, 3=500.
- coffee_make  in  1  level from the controller: brew requested.
- coin_return  in  1  level from the controller: return all credit.
- dispense_ack  in  1  dispenser has ejected the requested coin.
- coin  out  1  one-cycle pulse: a coin was accepted.
- coin_reject  out  1  one-cycle pulse: a coin was refused (mech returns it).
- coin_val  out  16  current credit.
- coffee_out  out  1  one-cycle pulse: brew finished.
- dispense_req  out  1  request to eject one coin.
- dispense_type  out  2  denomination to eject, same encoding as coin_type.

Behaviour:
- Reset: state IDLE; coin_val=0; all pulse outputs, dispense_req and dispense_type are 0; brew counter cleared. Reset aborts any brew or payout; no coffee_out is issued for an aborted brew.
- All outputs are registered; each pulse is exactly 1 cycle wide.
- States: IDLE, BREW, PAYOUT_REQ, PAYOUT_GAP.
- coffee_make is edge-detected with a registered copy; "make edge" means coffee_make=1 and its previous value was 0.
- IDLE, priority 1 (coin_return): if coin_return=1 and coin_val>0, go to PAYOUT_REQ. If coin_return=1 and coin_val=0, stay in IDLE.
- IDLE, priority 2 (make edge): on a make edge with coin_val>=COFFEE_VAL, set coin_val-=COFFEE_VAL at the same edge, load the brew counter, and go to BREW. A make edge with insufficient credit is ignored.
- IDLE, priority 3 (coin_ins):
  - Accept when coin_val+value(coin_type) <= CREDIT_MAX. Credit updates at the edge and coin=1 for the following cycle.
  - Otherwise credit is unchanged and coin_reject=1 for the following cycle.
  - coin_ins arriving in the same cycle as a higher-priority transition is rejected.
- BREW: the counter runs BREW_CYCLES cycles counted from the deduction edge. coffee_out pulses in the last cycle, then the state returns to IDLE. coin_ins during BREW is rejected; coin_return is ignored until IDLE.
- PAYOUT_REQ:
  - dispense_type = largest denomination <= coin_val; dispense_req=1.
  - Hold both stable until dispense_ack=1.
  - On ack: coin_val-=value, drop dispense_req, go to PAYOUT_GAP.
- PAYOUT_GAP: one cycle with req=0. Then go to PAYOUT_REQ if coin_val>0, else IDLE. coin_ins is rejected throughout payout.
- Arithmetic:
  - coin_val is unsigned 16-bit.
  - The add is checked against CREDIT_MAX before commit, so it never wraps.
  - The subtract only happens when coin_val >= the amount, so it never underflows.
  - All values are multiples of 10, so payout always terminates at exactly 0.
- An ack while dispense_req=0 is ignored.

Decomposition:
- coin_pkg holds:
  - coin-type encoding constants;
  - a denomination-value function (2-bit code to 16-bit value);
  - a largest-denomination-fitting function;
  - the state enum.
- Sub-module brew_timer (start, load value, done pulse) holds the down-counter; everything else lives in coin_bank.

Test Plan:
- Reset, then coin_ins with types 2,2,2 → three coin pulses; coin_val goes 100→200→300.
- coin_val=300, coffee_make raised → coin_val=0 next cycle; coffee_out pulses exactly BREW_CYCLES cycles after the deduction edge; coffee_make held high does not rebrew.
- coin_val=660, coin_return=1, dispenser acks after 3 cycles:
  - requests must arrive in order type3, type2, type1, type0;
  - coin_val goes 160, 60, 10, 0;
  - req is low for 1 cycle between coins;
  - ends in IDLE.
- coin_val=9900: insert 500 → coin_reject pulse, coin_val unchanged; insert 50 → accepted, coin_val=9950.
- coin_ins during BREW and during PAYOUT_REQ → coin_reject, credit unchanged; make edge with coin_val=250 → ignored.
- Assert reset mid-payout with req high → req=0 and coin_val=0 next cycle; no further dispense activity.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared coin encodings, denomination helpers and controller state for the
// coffee vending credit back end.
package coin_pkg;

   localparam logic [1:0] COIN_10  = 2'd0;
   localparam logic [1:0] COIN_50  = 2'd1;
   localparam logic [1:0] COIN_100 = 2'd2;
   localparam logic [1:0] COIN_500 = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      BREW,
      PAYOUT_REQ,
      PAYOUT_GAP
   } state_t;

   function automatic logic [15:0] coin_value(input logic [1:0] code);
      logic [15:0] value;
      case (code)
         COIN_10:  value = 16'd10;
         COIN_50:  value = 16'd50;
         COIN_100: value = 16'd100;
         default:  value = 16'd500;
      endcase
      return value;
   endfunction

   // Greedy change: the biggest coin that still fits in the remaining credit.
   function automatic logic [1:0] largest_coin(input logic [15:0] credit);
      logic [1:0] code;
      if (credit >= 16'd500)
         code = COIN_500;
      else if (credit >= 16'd100)
         code = COIN_100;
      else if (credit >= 16'd50)
         code = COIN_50;
      else
         code = COIN_10;
      return code;
   endfunction

endpackage

// File: rtl/brew_timer.sv
// Brew down-counter: loaded at the price deduction edge, emits a registered
// one-cycle done pulse in the final cycle of the brew.
module brew_timer #(
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] load,
   output logic             done
);

   logic [CNT_W-1:0] count;

   // Loading N-1 makes done land in the Nth cycle after the start edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            count <= load;
         end else if (count != '0) begin
            count <= count - 1'b1;
            done  <= (count == CNT_W'(1));
         end
      end
   end

endmodule

// File: rtl/coin_bank.sv
// Credit and coin-handling back end: accepts coins, deducts the coffee price,
// times the brew and pays change out through a req/ack dispenser handshake.
module coin_bank
   import coin_pkg::*;
#(
   parameter int COFFEE_VAL  = 300,
   parameter int BREW_CYCLES = 1000,
   parameter int CREDIT_MAX  = 9990
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        coin_ins,
   input  logic [1:0]  coin_type,
   input  logic        coffee_make,
   input  logic        coin_return,
   input  logic        dispense_ack,
   output logic        coin,
   output logic        coin_reject,
   output logic [15:0] coin_val,
   output logic        coffee_out,
   output logic        dispense_req,
   output logic [1:0]  dispense_type
);

   localparam int          CNT_W = $clog2(BREW_CYCLES + 1);
   localparam logic [15:0] PRICE = 16'(COFFEE_VAL);
   localparam logic [16:0] LIMIT = 17'(CREDIT_MAX);

   state_t      state;
   logic        make_prev;
   logic        make_edge;
   logic        take_return;
   logic        take_make;
   logic [16:0] sum;
   logic        brew_done;

   always_comb begin
      make_edge   = coffee_make & ~make_prev;
      take_return = (state == IDLE) && coin_return && (coin_val != 16'd0);
      take_make   = (state == IDLE) && !take_return && make_edge && (coin_val >= PRICE);
      sum         = {1'b0, coin_val} + {1'b0, coin_value(coin_type)};
   end

   brew_timer #(
      .CNT_W (CNT_W)
   ) u_brew_timer (
      .clk   (clk),
      .reset (reset),
      .start (take_make),
      .load  (CNT_W'(BREW_CYCLES - 1)),
      .done  (brew_done)
   );

   assign coffee_out = brew_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         coin_val      <= 16'd0;
         coin          <= 1'b0;
         coin_reject   <= 1'b0;
         dispense_req  <= 1'b0;
         dispense_type <= COIN_10;
         make_prev     <= 1'b0;
      end else begin
         make_prev   <= coffee_make;
         coin        <= 1'b0;
         coin_reject <= 1'b0;

         // Coins are only taken in an idle cycle with no competing transition.
         if (coin_ins) begin
            if ((state == IDLE) && !take_return && !take_make && (sum <= LIMIT)) begin
               coin_val <= sum[15:0];
               coin     <= 1'b1;
            end else begin
               coin_reject <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (take_return) begin
                  state         <= PAYOUT_REQ;
                  dispense_req  <= 1'b1;
                  dispense_type <= largest_coin(coin_val);
               end else if (take_make) begin
                  coin_val <= coin_val - PRICE;
                  state    <= BREW;
               end
            end
            BREW: begin
               if (brew_done)
                  state <= IDLE;
            end
            PAYOUT_REQ: begin
               if (dispense_ack && dispense_req) begin
                  coin_val     <= coin_val - coin_value(dispense_type);
                  dispense_req <= 1'b0;
                  state        <= PAYOUT_GAP;
               end
            end
            PAYOUT_GAP: begin
               if (coin_val != 16'd0) begin
                  state         <= PAYOUT_REQ;
                  dispense_req  <= 1'b1;
                  dispense_type <= largest_coin(coin_val);
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_coin_bank.sv
// Scoreboard bench for coin_bank: stimulus queues expected coin, brew and
// dispense events; a negedge monitor pops and compares as the DUT emits them.
module tb_coin_bank;

   localparam int N = 12;

   localparam int K_COIN = 0;
   localparam int K_REJ  = 1;

   typedef struct packed {
      int a;
      int b;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        coin_ins = 1'b0;
   logic [1:0]  coin_type = 2'd0;
   logic        coffee_make = 1'b0;
   logic        coin_return = 1'b0;
   logic        ack_auto = 1'b0;
   logic        ack_manual = 1'b0;
   logic        ack_en = 1'b0;
   logic        dispense_ack;
   logic        coin;
   logic        coin_reject;
   logic [15:0] coin_val;
   logic        coffee_out;
   logic        dispense_req;
   logic [1:0]  dispense_type;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int ack_cnt = 0;
   int gap_cnt = 0;
   int cur_type = 0;
   logic had_coin = 1'b0;
   logic prev_req = 1'b0;

   ev_t coin_q[$];
   ev_t coffee_q[$];
   ev_t disp_q[$];

   assign dispense_ack = ack_auto | ack_manual;

   coin_bank #(
      .COFFEE_VAL  (300),
      .BREW_CYCLES (N),
      .CREDIT_MAX  (9990)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .coin_ins      (coin_ins),
      .coin_type     (coin_type),
      .coffee_make   (coffee_make),
      .coin_return   (coin_return),
      .dispense_ack  (dispense_ack),
      .coin          (coin),
      .coin_reject   (coin_reject),
      .coin_val      (coin_val),
      .coffee_out    (coffee_out),
      .dispense_req  (dispense_req),
      .dispense_type (dispense_type)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      failures++;
      $display("FAIL %s: event with no expectation queued (cycle %0d)", name, cyc);
   endtask

   // Dispenser model: acknowledges a held request on its third sampled cycle.
   always @(negedge clk) begin
      if (ack_auto) begin
         ack_auto = 1'b0;
         ack_cnt  = 0;
      end else if (ack_en && dispense_req) begin
         ack_cnt++;
         if (ack_cnt == 3) ack_auto = 1'b1;
      end else begin
         ack_cnt = 0;
      end
   end

   always @(negedge clk) begin
      ev_t e;
      if (!reset) begin
         if (coin || coin_reject) begin
            if (coin_q.size() == 0) begin
               unexpected("coin_event");
            end else begin
               e = coin_q.pop_front();
               check("coin_kind", coin ? K_COIN : K_REJ, e.a);
               check("coin_credit", 32'(coin_val), e.b);
            end
         end
         if (coffee_out) begin
            if (coffee_q.size() == 0) begin
               unexpected("coffee_out");
            end else begin
               e = coffee_q.pop_front();
               check("coffee_cycle", cyc, e.a);
               check("coffee_credit", 32'(coin_val), e.b);
            end
         end
         if (dispense_req && !prev_req) begin
            if (had_coin) check("dispense_gap", gap_cnt, 1);
            had_coin = 1'b1;
            gap_cnt  = 0;
            if (disp_q.size() == 0) begin
               unexpected("dispense_req");
            end else begin
               e = disp_q.pop_front();
               cur_type = e.a;
               check("dispense_type", 32'(dispense_type), e.a);
               check("dispense_credit", 32'(coin_val), e.b);
            end
         end else if (dispense_req) begin
            check("dispense_hold", 32'(dispense_type), cur_type);
         end else begin
            gap_cnt++;
            if (coin_val == 16'd0) had_coin = 1'b0;
         end
      end
      prev_req = dispense_req;
   end

   task automatic ins(input int t, input int acc, input int expv);
      @(negedge clk);
      coin_ins  = 1'b1;
      coin_type = 2'(t);
      coin_q.push_back('{acc ? K_COIN : K_REJ, expv});
      @(negedge clk);
      coin_ins = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_coin_val", 32'(coin_val), 0);
      check("rst_coin", 32'(coin), 0);
      check("rst_reject", 32'(coin_reject), 0);
      check("rst_coffee", 32'(coffee_out), 0);
      check("rst_req", 32'(dispense_req), 0);
      check("rst_type", 32'(dispense_type), 0);
      reset = 1'b0;

      // Three 100-unit coins
      ins(2, 1, 100);
      ins(2, 1, 200);
      ins(2, 1, 300);

      // Brew with make held high; coin during brew is refused
      @(negedge clk);
      coffee_make = 1'b1;
      coffee_q.push_back('{cyc + N, 0});
      @(negedge clk);
      check("brew_deduct", 32'(coin_val), 0);
      ins(0, 0, 0);
      repeat (N + 2) @(negedge clk);
      ins(3, 1, 500);
      repeat (4) @(negedge clk);
      check("no_rebrew_credit", 32'(coin_val), 500);
      coffee_make = 1'b0;

      // Build 660 and pay it out greedily
      ins(2, 1, 600);
      ins(1, 1, 650);
      ins(0, 1, 660);
      ack_en = 1'b1;
      disp_q.push_back('{3, 660});
      disp_q.push_back('{2, 160});
      disp_q.push_back('{1, 60});
      disp_q.push_back('{0, 10});
      @(negedge clk);
      coin_return = 1'b1;
      ins(0, 0, 660);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (coin_val == 16'd0 && !dispense_req) break;
      end
      check("payout_credit", 32'(coin_val), 0);
      repeat (3) @(negedge clk);
      check("payout_idle_req", 32'(dispense_req), 0);
      coin_return = 1'b0;
      ack_en = 1'b0;

      // Make edge with 250 is ignored; a stray ack does nothing
      ins(2, 1, 100);
      ins(2, 1, 200);
      ins(1, 1, 250);
      @(negedge clk);
      coffee_make = 1'b1;
      repeat (3) @(negedge clk);
      check("make_low_credit", 32'(coin_val), 250);
      coffee_make = 1'b0;
      @(negedge clk);
      ack_manual = 1'b1;
      @(negedge clk);
      ack_manual = 1'b0;
      @(negedge clk);
      check("stray_ack_credit", 32'(coin_val), 250);
      check("stray_ack_req", 32'(dispense_req), 0);

      // Fill toward the credit ceiling
      for (int i = 0; i < 19; i++) ins(3, 1, 250 + 500 * (i + 1));
      ins(2, 1, 9850);
      ins(1, 1, 9900);
      ins(3, 0, 9900);
      ins(1, 1, 9950);
      ins(1, 0, 9950);

      // Reset while a request is outstanding
      disp_q.push_back('{3, 9950});
      @(negedge clk);
      coin_return = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (dispense_req) break;
      end
      check("abort_req_seen", 32'(dispense_req), 1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      coin_return = 1'b0;
      @(negedge clk);
      check("abort_req", 32'(dispense_req), 0);
      check("abort_credit", 32'(coin_val), 0);
      check("abort_type", 32'(dispense_type), 0);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("abort_quiet_req", 32'(dispense_req), 0);
      check("abort_quiet_credit", 32'(coin_val), 0);

      check("coin_q_empty", coin_q.size(), 0);
      check("coffee_q_empty", coffee_q.size(), 0);
      check("disp_q_empty", disp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
